cmac_seq: RTL

CMAC_SEQ -- requirements
Module: cmac_seq

---
 rtl/cmac_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cmac_seq.sv
// Complex dot-product sequencer: feeds operand pairs to an external combinational CMAC
// and walks it through multiply / accumulate / readback for each element.
module cmac_seq #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_r,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_r,
    input  logic [DATA_W-1:0] y_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res_r,
    output logic [DATA_W-1:0] res_i,
    output logic              res_ovf,
    output logic [DATA_W-1:0] cm_a_r,
    output logic [DATA_W-1:0] cm_a_i,
    output logic [DATA_W-1:0] cm_b_r,
    output logic [DATA_W-1:0] cm_b_i,
    output logic              cm_acc,
    output logic              cm_abs,
    output logic              cm_acc_en,
    output logic              cm_mult_en,
    input  logic [DATA_W-1:0] cm_s_r,
    input  logic [DATA_W-1:0] cm_s_i,
    input  logic              cm_ovf
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] MUL   = 3'd2;
    localparam logic [2:0] ACC   = 3'd3;
    localparam logic [2:0] READ  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]               state;
    logic [LEN_W-1:0]         count;
    logic                     first;
    logic                     ovf;
    logic signed [DATA_W-1:0] op_xr, op_xi, op_yr, op_yi;
    logic signed [DATA_W-1:0] prod_r, prod_i;
    logic signed [DATA_W-1:0] acc_r, acc_i;

    wire last = (count == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            first  <= 1'b0;
            ovf    <= 1'b0;
            op_xr  <= '0;
            op_xi  <= '0;
            op_yr  <= '0;
            op_yi  <= '0;
            prod_r <= '0;
            prod_i <= '0;
            acc_r  <= '0;
            acc_i  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= len;
                        ovf   <= 1'b0;
                        first <= 1'b1;
                        if (len == '0) begin
                            acc_r <= '0;
                            acc_i <= '0;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        op_xr <= x_r;
                        op_xi <= x_i;
                        op_yr <= y_r;
                        op_yi <= y_i;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // First product goes straight into the CMAC accumulator; later ones detour via prod_*
                    if (first) begin
                        first <= 1'b0;
                        count <= count - LEN_W'(1);
                        state <= last ? READ : FETCH;
                    end else begin
                        prod_r <= cm_s_r;
                        prod_i <= cm_s_i;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    ovf   <= ovf | cm_ovf;
                    count <= count - LEN_W'(1);
                    state <= last ? READ : FETCH;
                end
                READ: begin
                    acc_r <= cm_s_r;
                    acc_i <= cm_s_i;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == FETCH);
    assign out_valid = (state == DONE);
    assign res_r     = acc_r;
    assign res_i     = acc_i;
    assign res_ovf   = ovf;
    assign cm_abs     = 1'b0;
    assign cm_mult_en = 1'b0;

    always_comb begin
        cm_a_r    = '0;
        cm_a_i    = '0;
        cm_b_r    = '0;
        cm_b_i    = '0;
        cm_acc    = 1'b0;
        cm_acc_en = 1'b0;
        case (state)
            MUL: begin
                cm_a_r    = op_xr;
                cm_a_i    = op_xi;
                cm_b_r    = op_yr;
                cm_b_i    = op_yi;
                cm_acc_en = first;
            end
            ACC: begin
                cm_a_r    = prod_r;
                cm_a_i    = prod_i;
                cm_acc    = 1'b1;
                cm_acc_en = 1'b1;
            end
            // A=0 in accumulate mode reads the accumulator back unchanged
            READ: cm_acc = 1'b1;
            default: ;
        endcase
    end

endmodule
